// File: rtl/nbcac_4di_stream_encoder.sv
// Transmit end of the 5-wire NBCAC link: encodes 4-bit words into forbidden-pattern-free
// codewords and streams them out of a small FIFO with valid/ready handshakes.
module nbcac_4di_stream_encoder #(
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = 16,
  parameter logic [4:0]  IDLE_CODE = 5'b00000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [3:0]       datain,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [4:0]       codeout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sent_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // v-th FPF word in ascending binary order; the decoder relies on this exact table.
  function automatic logic [4:0] fpf_encode(input logic [3:0] v);
    case (v)
      4'd0:    fpf_encode = 5'b00000;
      4'd1:    fpf_encode = 5'b00001;
      4'd2:    fpf_encode = 5'b00011;
      4'd3:    fpf_encode = 5'b00110;
      4'd4:    fpf_encode = 5'b00111;
      4'd5:    fpf_encode = 5'b01100;
      4'd6:    fpf_encode = 5'b01110;
      4'd7:    fpf_encode = 5'b01111;
      4'd8:    fpf_encode = 5'b10000;
      4'd9:    fpf_encode = 5'b10001;
      4'd10:   fpf_encode = 5'b10011;
      4'd11:   fpf_encode = 5'b11000;
      4'd12:   fpf_encode = 5'b11001;
      4'd13:   fpf_encode = 5'b11100;
      4'd14:   fpf_encode = 5'b11110;
      default: fpf_encode = 5'b11111;
    endcase
  endfunction

  logic [DEPTH-1:0][4:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [4:0]            code_q, code_d;
  logic                  vld_q, vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [4:0] enc_word;
  logic       full, push, pop, drained;

  assign enc_word = fpf_encode(datain);
  assign full     = (occ_q == OCC_W'(DEPTH));

  // Ready depends only on registered occupancy; forced low while reset is held.
  assign in_ready = ~rst & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = vld_q & out_ready;
  // Queue has nothing left behind the head once this cycle's pop is taken.
  assign drained  = (occ_q == OCC_W'(pop));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    cnt_d    = cnt_q + CNT_W'(pop);
    vld_d    = (occ_d != '0);
    code_d   = code_q;
    if (occ_d != '0) begin
      // New head is either the word being pushed now (bypass) or already stored.
      code_d = drained ? enc_word : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      code_q   <= IDLE_CODE;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      code_q   <= code_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
    end
  end

  assign codeout    = code_q;
  assign out_valid  = vld_q;
  assign sent_count = cnt_q;

endmodule
